// File: rtl/enc_msg_pkg.sv
// Host-link message encoder: event indices, protocol byte codes and the encode helper
// shared by the encoder top and its bench-facing users.
package enc_msg_pkg;

    localparam int NUM_EVT   = 9;
    localparam int EVT_IDX_W = 4;

    localparam int EVT_TURN        = 0;
    localparam int EVT_DRAW        = 1;
    localparam int EVT_RESIGN      = 2;
    localparam int EVT_RESET_DONE  = 3;
    localparam int EVT_OFFSET_DONE = 4;
    localparam int EVT_MOVE        = 5;
    localparam int EVT_SCAN_L      = 6;
    localparam int EVT_SCAN_R      = 7;
    localparam int EVT_NEWGAME     = 8;

    localparam logic [7:0] MSG_TURN        = 8'h00;
    localparam logic [7:0] MSG_DRAW        = 8'h10;
    localparam logic [7:0] MSG_RESIGN      = 8'h20;
    localparam logic [7:0] MSG_RESET_DONE  = 8'h7F;
    localparam logic [7:0] MSG_OFFSET_DONE = 8'h79;

    localparam logic [1:0] PFX_MOVE    = 2'b01;
    localparam logic [2:0] PFX_SCAN_L  = 3'b101;
    localparam logic [2:0] PFX_SCAN_R  = 3'b100;
    localparam logic [1:0] PFX_NEWGAME = 2'b11;

    typedef logic [EVT_IDX_W-1:0] evt_idx_t;
    typedef logic [NUM_EVT-1:0]   evt_vec_t;

    typedef struct packed {
        logic [2:0] move_sq;
        logic [4:0] pieces;
        logic [2:0] black;
        logic [2:0] white;
    } enc_payload_t;

    function automatic logic [7:0] enc_msg(input evt_idx_t idx, input enc_payload_t pl);
        logic [7:0] m;
        case (int'(idx))
            EVT_TURN:        m = MSG_TURN;
            EVT_DRAW:        m = MSG_DRAW;
            EVT_RESIGN:      m = MSG_RESIGN;
            EVT_RESET_DONE:  m = MSG_RESET_DONE;
            EVT_OFFSET_DONE: m = MSG_OFFSET_DONE;
            EVT_MOVE:        m = {PFX_MOVE, pl.move_sq, 3'b000};
            EVT_SCAN_L:      m = {PFX_SCAN_L, pl.pieces};
            EVT_SCAN_R:      m = {PFX_SCAN_R, pl.pieces};
            default:         m = {PFX_NEWGAME, pl.black, pl.white};
        endcase
        return m;
    endfunction

endpackage

// File: rtl/enc_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count; read data is
// forced to zero while empty so the head byte never shows stale storage.
module enc_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_wr, do_rd;

    assign empty = (cnt == '0);
    assign full  = (cnt == CW'(DEPTH));
    // full blocks the write even when a read happens in the same cycle
    assign do_wr = wr_en & ~full;
    assign do_rd = rd_en & ~empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = empty ? '0 : mem[rd_ptr];
    assign count   = cnt;

endmodule

// File: rtl/msg_encoder_fifo.sv
// Event-to-host-byte encoder: sticky edge-captured requests, one grant per cycle into
// a FWFT queue. Define ENC_OVF_COUNT_EN to build the saturating merge counter.
module msg_encoder_fifo
    import enc_msg_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int PRIO_MODE  = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [8:0]                    evt,
    input  logic [2:0]                    move_sq,
    input  logic [4:0]                    pieces,
    input  logic [2:0]                    black_setting,
    input  logic [2:0]                    white_setting,
    output logic [7:0]                    tx_data,
    output logic                          tx_valid,
    input  logic                          tx_ready,
    output logic [8:0]                    pending,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          ovf,
    output logic [7:0]                    ovf_count,
    output logic [7:0]                    ledg,
    output logic                          ledr
);
    localparam evt_idx_t LAST_IDX = evt_idx_t'(NUM_EVT - 1);

    evt_vec_t     evt_prev, rise, pending_q, grant, merge;
    enc_payload_t pl_q;
    evt_idx_t     grant_idx, rr_ptr, scan;
    logic         found, push, fifo_full, fifo_empty;
    logic [7:0]   push_data;

    assign rise  = evt & ~evt_prev;
    assign push  = (|pending_q) & ~fifo_full;
    assign grant = push ? (evt_vec_t'(1) << grant_idx) : '0;
    // a fresh rise on a request still waiting (and not granted now) collapses into it
    assign merge = rise & pending_q & ~grant;

    // Scan all indices once, starting at 0 (fixed) or just past the last grant (round-robin).
    always_comb begin
        grant_idx = '0;
        found     = 1'b0;
        scan      = (PRIO_MODE == 1 && rr_ptr != LAST_IDX) ? rr_ptr + 1'b1 : '0;
        for (int k = 0; k < NUM_EVT; k++) begin
            if (!found && pending_q[scan]) begin
                found     = 1'b1;
                grant_idx = scan;
            end
            scan = (scan == LAST_IDX) ? '0 : scan + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            evt_prev  <= '0;
            pending_q <= '0;
            pl_q      <= '0;
            ovf       <= 1'b0;
            rr_ptr    <= LAST_IDX;
        end else begin
            evt_prev  <= evt;
            pending_q <= (pending_q & ~grant) | rise;
            if (|merge) ovf <= 1'b1;
            if (push)   rr_ptr <= grant_idx;
            if (rise[EVT_MOVE]) pl_q.move_sq <= move_sq;
            if (rise[EVT_SCAN_L] | rise[EVT_SCAN_R]) pl_q.pieces <= pieces;
            if (rise[EVT_NEWGAME]) begin
                pl_q.black <= black_setting;
                pl_q.white <= white_setting;
            end
        end
    end

`ifdef ENC_OVF_COUNT_EN
    logic [7:0] ovf_cnt_q;
    logic [8:0] ovf_sum;

    assign ovf_sum = {1'b0, ovf_cnt_q} + 9'($countones(merge));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) ovf_cnt_q <= '0;
        else       ovf_cnt_q <= ovf_sum[8] ? 8'hFF : ovf_sum[7:0];
    end

    assign ovf_count = ovf_cnt_q;
`else
    assign ovf_count = '0;
`endif

    assign push_data = enc_msg(grant_idx, pl_q);

    enc_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .wr_en   (push),
        .wr_data (push_data),
        .rd_en   (tx_ready),
        .rd_data (tx_data),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .count   (fifo_count)
    );

    assign tx_valid = ~fifo_empty;
    assign pending  = pending_q;
    assign ledg     = tx_data;
    assign ledr     = tx_valid;

endmodule

// File: tb/tb_msg_encoder_fifo.sv
// Bench for msg_encoder_fifo: a depth-4 fixed-priority and a depth-8 round-robin instance
// share one stimulus stream and are each checked every cycle against a queue model.
module tb_msg_encoder_fifo;

    logic       clk, reset, tx_ready;
    logic [8:0] evt;
    logic [2:0] move_sq, black_setting, white_setting;
    logic [4:0] pieces;

    logic [7:0] tx_data0, tx_data1, ovfc0, ovfc1, ledg0, ledg1;
    logic       tx_valid0, tx_valid1, ovf0, ovf1, ledr0, ledr1;
    logic [8:0] pending0, pending1;
    logic [2:0] fc0;
    logic [3:0] fc1;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

`ifdef ENC_OVF_COUNT_EN
    localparam int EXP_MERGE_CNT = 1;
`else
    localparam int EXP_MERGE_CNT = 0;
`endif

    msg_encoder_fifo #(.FIFO_DEPTH(4), .PRIO_MODE(0)) u_fix (
        .clk(clk), .reset(reset), .evt(evt), .move_sq(move_sq), .pieces(pieces),
        .black_setting(black_setting), .white_setting(white_setting),
        .tx_data(tx_data0), .tx_valid(tx_valid0), .tx_ready(tx_ready),
        .pending(pending0), .fifo_count(fc0), .ovf(ovf0), .ovf_count(ovfc0),
        .ledg(ledg0), .ledr(ledr0)
    );

    msg_encoder_fifo #(.FIFO_DEPTH(8), .PRIO_MODE(1)) u_rr (
        .clk(clk), .reset(reset), .evt(evt), .move_sq(move_sq), .pieces(pieces),
        .black_setting(black_setting), .white_setting(white_setting),
        .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready),
        .pending(pending1), .fifo_count(fc1), .ovf(ovf1), .ovf_count(ovfc1),
        .ledg(ledg1), .ledr(ledr1)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [8:0] m_prev [2];
    logic [8:0] m_pend [2];
    logic [2:0] m_mv [2];
    logic [4:0] m_pc [2];
    logic [2:0] m_bk [2];
    logic [2:0] m_wt [2];
    int         m_rr [2];
    bit         m_ovf [2];
    int         m_ovfc [2];
    logic [7:0] mq0 [$];
    logic [7:0] mq1 [$];
    logic [7:0] log0 [$];
    logic [7:0] log1 [$];

    function automatic logic [7:0] ref_enc(input int idx, input logic [2:0] mv,
                                           input logic [4:0] pc, input logic [2:0] bk,
                                           input logic [2:0] wt);
        case (idx)
            0: return 8'h00;
            1: return 8'h10;
            2: return 8'h20;
            3: return 8'h7F;
            4: return 8'h79;
            5: return {2'b01, mv, 3'b000};
            6: return {3'b101, pc};
            7: return {3'b100, pc};
            default: return {2'b11, bk, wt};
        endcase
    endfunction

    function automatic int qsz(input int i);
        return (i == 0) ? mq0.size() : mq1.size();
    endfunction

    function automatic logic [7:0] qhead(input int i);
        if (qsz(i) == 0) return 8'h00;
        return (i == 0) ? mq0[0] : mq1[0];
    endfunction

    function automatic int exp_ovfc(input int i);
`ifdef ENC_OVF_COUNT_EN
        return m_ovfc[i];
`else
        return (i < 0) ? m_ovfc[0] : 0;
`endif
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            m_prev[i] = '0; m_pend[i] = '0; m_mv[i] = '0; m_pc[i] = '0;
            m_bk[i] = '0; m_wt[i] = '0; m_rr[i] = 8; m_ovf[i] = 0; m_ovfc[i] = 0;
        end
        mq0.delete();
        mq1.delete();
    endtask

    task automatic model_step(input int i);
        logic [8:0] rise, g, merge, p;
        logic [7:0] b;
        int depth, sz, sel, c;
        rise  = evt & ~m_prev[i];
        depth = (i == 0) ? 4 : 8;
        sz    = qsz(i);
        p     = m_pend[i];
        g     = '0;
        b     = '0;
        sel   = -1;
        if (p != 0 && sz < depth) begin
            if (i == 0) begin
                for (int k = 0; k < 9; k++) if (sel < 0 && p[k[3:0]]) sel = k;
            end else begin
                for (int k = 1; k <= 9; k++) begin
                    c = (m_rr[i] + k) % 9;
                    if (sel < 0 && p[c[3:0]]) sel = c;
                end
            end
            g[sel[3:0]] = 1'b1;
            b = ref_enc(sel, m_mv[i], m_pc[i], m_bk[i], m_wt[i]);
            m_rr[i] = sel;
        end
        if (sz > 0 && tx_ready) begin
            if (i == 0) void'(mq0.pop_front()); else void'(mq1.pop_front());
        end
        if (sel >= 0) begin
            if (i == 0) mq0.push_back(b); else mq1.push_back(b);
        end
        merge = rise & p & ~g;
        if (merge != 0) m_ovf[i] = 1;
        m_ovfc[i] = m_ovfc[i] + $countones(merge);
        if (m_ovfc[i] > 255) m_ovfc[i] = 255;
        m_pend[i] = (p & ~g) | rise;
        if (rise[5]) m_mv[i] = move_sq;
        if (rise[6] || rise[7]) m_pc[i] = pieces;
        if (rise[8]) begin m_bk[i] = black_setting; m_wt[i] = white_setting; end
        m_prev[i] = evt;
    endtask

    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) model_clear();
        else for (int i = 0; i < 2; i++) model_step(i);
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("tx_valid0", 32'(tx_valid0), 32'(qsz(0) != 0));
            chk("tx_data0",  32'(tx_data0),  32'(qhead(0)));
            chk("ledg0",     32'(ledg0),     32'(qhead(0)));
            chk("ledr0",     32'(ledr0),     32'(qsz(0) != 0));
            chk("pending0",  32'(pending0),  32'(m_pend[0]));
            chk("count0",    32'(fc0),       32'(qsz(0)));
            chk("ovf0",      32'(ovf0),      32'(m_ovf[0]));
            chk("ovfcnt0",   32'(ovfc0),     32'(exp_ovfc(0)));
            chk("tx_valid1", 32'(tx_valid1), 32'(qsz(1) != 0));
            chk("tx_data1",  32'(tx_data1),  32'(qhead(1)));
            chk("ledg1",     32'(ledg1),     32'(qhead(1)));
            chk("ledr1",     32'(ledr1),     32'(qsz(1) != 0));
            chk("pending1",  32'(pending1),  32'(m_pend[1]));
            chk("count1",    32'(fc1),       32'(qsz(1)));
            chk("ovf1",      32'(ovf1),      32'(m_ovf[1]));
            chk("ovfcnt1",   32'(ovfc1),     32'(exp_ovfc(1)));
        end
        if (tx_valid0 && tx_ready) log0.push_back(tx_data0);
        if (tx_valid1 && tx_ready) log1.push_back(tx_data1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int thr;
        logic [7:0] exp_seq [7];
        evt = '0; move_sq = '0; pieces = '0; black_setting = '0; white_setting = '0;
        tx_ready = 0; reset = 0;
        #1 reset = 1;
        repeat (3) step();
        chk("rst_valid", 32'(tx_valid0), 32'(0));
        chk("rst_data",  32'(tx_data0),  32'(0));
        chk("rst_pend",  32'(pending0),  32'(0));
        chk("rst_count", 32'(fc1),       32'(0));
        chk("rst_ovf",   32'(ovf1),      32'(0));
        chk("rst_ovfc",  32'(ovfc0),     32'(0));
        reset  = 0;
        chk_en = 1;

        // single pulse: pending next cycle, byte visible one cycle after that
        tx_ready = 1;
        evt = 9'h001; step();
        evt = 9'h000;
        chk("pulse_pend", 32'(pending0), 32'h001);
        chk("pulse_nov",  32'(tx_valid0), 32'(0));
        step();
        chk("pulse_valid", 32'(tx_valid0), 32'(1));
        chk("pulse_data",  32'(tx_data0),  32'h00);
        step();
        chk("pulse_drain", 32'(fc0), 32'(0));

        // simultaneous resign + new game
        repeat (2) step();
        tx_ready = 0; black_setting = 3'b010; white_setting = 3'b101;
        evt = 9'h104; step();
        evt = 9'h000;
        repeat (3) step();
        chk("simul_cnt",  32'(fc0),      32'(2));
        chk("simul_head", 32'(tx_data0), 32'h20);
        tx_ready = 1; step();
        chk("simul_2nd", 32'(tx_data0), 32'hD5);
        step();
        chk("simul_empty", 32'(tx_valid0), 32'(0));

        // fill the depth-4 queue, then merge a scan-left request while blocked
        tx_ready = 0; move_sq = 3'b001;
        evt = 9'h03F; step();
        evt = 9'h000;
        repeat (8) step();
        chk("full_cnt",  32'(fc0),      32'(4));
        chk("full_pend", 32'(pending0), 32'h030);
        pieces = 5'd5; evt = 9'h040; step();
        evt = 9'h000; pieces = 5'd0; step();
        pieces = 5'd9; evt = 9'h040; step();
        evt = 9'h000; step();
        chk("merge_ovf",  32'(ovf0),     32'(1));
        chk("merge_cnt",  32'(ovfc0),    32'(EXP_MERGE_CNT));
        chk("merge_pend", 32'(pending0), 32'h070);
        log0.delete();
        tx_ready = 1;
        repeat (12) step();
        exp_seq = '{8'h00, 8'h10, 8'h20, 8'h7F, 8'h79, 8'h48, 8'hA9};
        chk("drain_len", 32'(log0.size()), 32'(7));
        for (int k = 0; k < 7 && k < log0.size(); k++)
            chk("drain_seq", 32'(log0[k]), 32'(exp_seq[k]));

        // round-robin instance: two requests re-pulsed every 3 cycles
        log1.delete();
        repeat (6) begin
            evt = 9'h003; step();
            evt = 9'h000; step(); step();
        end
        repeat (4) step();
        chk("rr_len", 32'(log1.size()), 32'(12));
        for (int k = 0; k + 1 < log1.size(); k++)
            chk("rr_alt", 32'(log1[k] != log1[k + 1]), 32'(1));

        // reset with bytes queued, reset_done held across release
        tx_ready = 0;
        evt = 9'h007; step();
        evt = 9'h000;
        repeat (4) step();
        chk("mid_cnt", 32'(fc0), 32'(3));
        evt = 9'h008; reset = 1;
        #1;
        chk("arst_valid", 32'(tx_valid0), 32'(0));
        chk("arst_pend",  32'(pending1),  32'(0));
        chk("arst_count", 32'(fc0),       32'(0));
        chk("arst_ovf",   32'(ovf0),      32'(0));
        step(); step();
        reset = 0; tx_ready = 1;
        log0.delete();
        repeat (10) step();
        evt = 9'h000; step();
        chk("held_len",  32'(log0.size()), 32'(1));
        if (log0.size() > 0) chk("held_byte", 32'(log0[0]), 32'h7F);

        // randomized traffic with phased back-pressure and rare resets
        for (int cyc = 0; cyc < 3000; cyc++) begin
            case ((cyc / 250) % 4)
                0: thr = 90;
                1: thr = 50;
                2: thr = 15;
                default: thr = 0;
            endcase
            evt = evt ^ (9'($urandom) & 9'($urandom) & 9'($urandom));
            move_sq = 3'($urandom); pieces = 5'($urandom);
            black_setting = 3'($urandom); white_setting = 3'($urandom);
            tx_ready = ($urandom_range(0, 99) < thr);
            reset = ($urandom_range(0, 999) == 0);
            step();
        end
        reset = 0; evt = '0; tx_ready = 1;
        repeat (30) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
